// File: rtl/road_scroll_renderer.sv
// Road scroll renderer: classifies each scan pixel into grass, road, painted
// lines or lane dividers, scrolls the dashed dividers by a per-frame distance,
// and blinks the edge lines orange while the hazard signal is held.
// Two-stage pixel pipeline: stage 1 holds the colour class, stage 2 holds RGB.
module road_scroll_renderer #(
  parameter int NUM_LANES  = 4,
  parameter int ROAD_X0    = 145,
  parameter int SHOULDER_W = 10,
  parameter int LINE_W     = 10,
  parameter int LANE_W     = 70,
  parameter int DASH_LOG2  = 6,
  parameter int BLINK_LOG2 = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pix_valid_in,
  input  logic        frame_start,
  input  logic [3:0]  speed,
  input  logic        pause,
  input  logic        hazard,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        pix_valid_out,
  output logic [10:0] Distance
);

  // Road geometry, all measured in pixel columns.
  localparam int ROAD_SPAN  = 2*SHOULDER_W + (NUM_LANES+1)*LINE_W + NUM_LANES*LANE_W;
  localparam int ROAD_X1    = ROAD_X0 + ROAD_SPAN;
  localparam int LANE_P     = LANE_W + LINE_W;
  localparam int CENTER_DIV = NUM_LANES / 2;
  localparam bit HAS_CENTER = (NUM_LANES % 2) == 0;
  localparam int SCREEN_W   = 640;

  localparam logic [23:0] RGB_GRASS  = 24'h1C_A3_39;
  localparam logic [23:0] RGB_ROAD   = 24'h31_31_31;
  localparam logic [23:0] RGB_WHITE  = 24'hFF_FF_FF;
  localparam logic [23:0] RGB_ORANGE = 24'hF3_98_00;

  // CI_DASH is a dashed divider whose on/off phase is resolved in stage 2.
  typedef enum logic [2:0] {
    CI_GRASS,
    CI_ROAD,
    CI_WHITE,
    CI_ORANGE,
    CI_DASH
  } color_idx_e;

  logic [10:0] distance_q, distance_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic        valid1_q;
  logic [9:0]  x1_q;
  logic        dash1_q;
  color_idx_e  ci1_q, ci1_d;

  logic        valid2_q;
  logic [23:0] rgb2_q, rgb2_d;

  logic        blink_on;
  logic [9:0]  ydist;

  assign blink_on = hazard && frame_cnt_q[BLINK_LOG2];
  assign ydist    = DrawY - distance_q[9:0];

  // Scroll distance and hazard frame counter for the next cycle.
  always_comb begin
    distance_d  = distance_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start && !pause) distance_d = distance_q + 11'(speed);
    if (!hazard)          frame_cnt_d = 8'd0;
    else if (frame_start) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  // Stage-1 colour classification from the column position.
  always_comb begin
    // NOTE: every output of a comb block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    int x_int;
    int rel;
    int lane_rel;
    color_idx_e edge_ci;
    x_int    = int'({22'd0, DrawX});
    rel      = x_int - ROAD_X0;
    lane_rel = rel - SHOULDER_W - LINE_W;
    edge_ci  = blink_on ? CI_ORANGE : CI_WHITE;
    ci1_d    = CI_GRASS;
    if (x_int >= ROAD_X0 && x_int < ROAD_X1 && x_int < SCREEN_W) begin
      ci1_d = CI_ROAD;
      if (rel >= SHOULDER_W && rel < SHOULDER_W + LINE_W) begin
        ci1_d = edge_ci;
      end else if (rel >= ROAD_SPAN - SHOULDER_W - LINE_W &&
                   rel <  ROAD_SPAN - SHOULDER_W) begin
        ci1_d = edge_ci;
      end else begin
        // Divider k sits in the last LINE_W columns of lane period k.
        for (int k = 1; k < NUM_LANES; k++) begin
          if (lane_rel >= k*LANE_P - LINE_W && lane_rel < k*LANE_P) begin
            ci1_d = (HAS_CENTER && k == CENTER_DIV) ? CI_ORANGE : CI_DASH;
          end
        end
      end
    end
  end

  // Stage-2 palette lookup; blank when the stage-1 slot is empty.
  always_comb begin
    rgb2_d = 24'd0;
    if (valid1_q) begin
      unique case (ci1_q)
        CI_GRASS:  rgb2_d = RGB_GRASS;
        CI_ROAD:   rgb2_d = RGB_ROAD;
        CI_WHITE:  rgb2_d = RGB_WHITE;
        CI_ORANGE: rgb2_d = RGB_ORANGE;
        CI_DASH:   rgb2_d = dash1_q ? RGB_WHITE : RGB_ROAD;
        default:   rgb2_d = RGB_GRASS;
      endcase
      if (x1_q >= 10'(SCREEN_W)) rgb2_d = RGB_GRASS;
    end
  end

  // State registers: scroll, blink counter and both pipeline stages.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: the pipeline stages are cleared on reset (not just the valids)
    // so a reset mid-frame drops in-flight pixels and blanks RGB at once.
    if (!Reset_n) begin
      distance_q  <= 11'd0;
      frame_cnt_q <= 8'd0;
      valid1_q    <= 1'b0;
      x1_q        <= 10'd0;
      dash1_q     <= 1'b0;
      ci1_q       <= CI_GRASS;
      valid2_q    <= 1'b0;
      rgb2_q      <= 24'd0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, e.g. a pixel sharing a cycle with frame_start sees
      // the old distance.
      distance_q  <= distance_d;
      frame_cnt_q <= frame_cnt_d;
      valid1_q    <= pix_valid_in;
      x1_q        <= DrawX;
      dash1_q     <= ydist[DASH_LOG2];
      ci1_q       <= ci1_d;
      valid2_q    <= valid1_q;
      rgb2_q      <= rgb2_d;
    end
  end

  assign Red           = rgb2_q[23:16];
  assign Green         = rgb2_q[15:8];
  assign Blue          = rgb2_q[7:0];
  assign pix_valid_out = valid2_q;
  assign Distance      = distance_q;

endmodule

// File: tb/tb_road_scroll_renderer.sv
// Directed bench for road_scroll_renderer: default 4-lane instance plus a
// 3-lane instance sharing the same stimulus.
module tb_road_scroll_renderer;

  localparam logic [23:0] GRASS  = 24'h1CA339;
  localparam logic [23:0] ROAD   = 24'h313131;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  localparam logic [23:0] ORANGE = 24'hF39800;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        pix_valid_in = 1'b0, frame_start = 1'b0, pause = 1'b0, hazard = 1'b0;
  logic [3:0]  speed = '0;

  logic [7:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic        pvo_a, pvo_b;
  logic [10:0] dist_a, dist_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  road_scroll_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid_in(pix_valid_in), .frame_start(frame_start), .speed(speed),
    .pause(pause), .hazard(hazard), .Red(red_a), .Green(green_a), .Blue(blue_a),
    .pix_valid_out(pvo_a), .Distance(dist_a)
  );

  road_scroll_renderer #(.NUM_LANES(3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid_in(pix_valid_in), .frame_start(frame_start), .speed(speed),
    .pause(pause), .hazard(hazard), .Red(red_b), .Green(green_b), .Blue(blue_b),
    .pix_valid_out(pvo_b), .Distance(dist_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    frame_start = 1'b1;
    repeat (n) tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
  endtask

  // One isolated pixel; compare {valid, RGB} of the chosen instance 2 cycles later.
  task automatic pix(input string tag, input int x, input int y, input bit lanes3,
                     input logic [23:0] exp);
    DrawX = 10'(x);
    DrawY = 10'(y);
    pix_valid_in = 1'b1;
    tick();
    pix_valid_in = 1'b0;
    tick();
    if (lanes3) check(tag, {7'd0, pvo_b, red_b, green_b, blue_b}, {7'd0, 1'b1, exp});
    else        check(tag, {7'd0, pvo_a, red_a, green_a, blue_a}, {7'd0, 1'b1, exp});
  endtask

  initial begin
    // Reset state.
    Reset_n = 1'b0;
    #12;
    check("rst_rgb",   {8'd0, red_a, green_a, blue_a}, 32'd0);
    check("rst_valid", {31'd0, pvo_a}, 32'd0);
    check("rst_dist",  {21'd0, dist_a}, 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();

    // Back-to-back stream: each pixel emerges exactly 2 cycles later.
    DrawY = 10'd0;
    DrawX = 10'd0;   pix_valid_in = 1'b1;
    tick();
    check("lat_s1_empty", {31'd0, pvo_a}, 32'd0);
    DrawX = 10'd155;
    tick();
    check("stream0", {7'd0, pvo_a, red_a, green_a, blue_a}, {7'd0, 1'b1, GRASS});
    DrawX = 10'd315;
    tick();
    check("stream1", {7'd0, pvo_a, red_a, green_a, blue_a}, {7'd0, 1'b1, WHITE});
    pix_valid_in = 1'b0;
    tick();
    check("stream2", {7'd0, pvo_a, red_a, green_a, blue_a}, {7'd0, 1'b1, ORANGE});
    tick();
    check("stream_idle", {7'd0, pvo_a, red_a, green_a, blue_a}, 32'd0);

    // Row 0, Distance 0, default layout.
    pix("r0_x0",   0,   0, 0, GRASS);
    pix("r0_x144", 144, 0, 0, GRASS);
    pix("r0_x145", 145, 0, 0, ROAD);
    pix("r0_x154", 154, 0, 0, ROAD);
    pix("r0_x164", 164, 0, 0, WHITE);
    pix("r0_x165", 165, 0, 0, ROAD);
    pix("r0_x234", 234, 0, 0, ROAD);
    pix("r0_x240", 240, 0, 0, ROAD);
    pix("r0_x324", 324, 0, 0, ORANGE);
    pix("r0_x400", 400, 0, 0, ROAD);
    pix("r0_x475", 475, 0, 0, WHITE);
    pix("r0_x484", 484, 0, 0, WHITE);
    pix("r0_x494", 494, 0, 0, ROAD);
    pix("r0_x495", 495, 0, 0, GRASS);
    pix("r0_x639", 639, 0, 0, GRASS);
    pix("r0_x1023", 1023, 0, 0, GRASS);

    // Dash phase at Distance 0.
    pix("dash_y64", 240, 64, 0, WHITE);
    pix("dash_y63", 240, 63, 0, ROAD);
    pix("dash_x400_y64", 400, 64, 0, WHITE);

    // 3-lane layout: both dividers dashed, road ends at 415.
    pix("l3_x240_y64", 240, 64, 1, WHITE);
    pix("l3_x320_y64", 320, 64, 1, WHITE);
    pix("l3_x320_y0",  320, 0,  1, ROAD);
    pix("l3_x400",     400, 0,  1, WHITE);
    pix("l3_x410",     410, 0,  1, ROAD);
    pix("l3_x415",     415, 0,  1, GRASS);

    // Pixel sharing a cycle with frame_start uses the old Distance.
    speed = 4'd1;
    DrawX = 10'd240; DrawY = 10'd64; pix_valid_in = 1'b1; frame_start = 1'b1;
    tick();
    pix_valid_in = 1'b0; frame_start = 1'b0;
    tick();
    check("same_cycle_pix", {7'd0, pvo_a, red_a, green_a, blue_a}, {7'd0, 1'b1, WHITE});
    check("dist_1", {21'd0, dist_a}, 32'd1);
    pix("d1_y64", 240, 64, 0, ROAD);
    pix("d1_y65", 240, 65, 0, WHITE);

    // Hazard blink on the edge lines only.
    speed = 4'd0;
    hazard = 1'b1;
    frames(16);
    pix("haz16_left",  160, 0,  0, ORANGE);
    pix("haz16_right", 480, 0,  0, ORANGE);
    pix("haz16_div",   240, 65, 0, WHITE);
    frames(16);
    pix("haz32_left",  160, 0,  0, WHITE);
    frames(16);
    pix("haz48_left",  160, 0,  0, ORANGE);
    hazard = 1'b0;
    tick();
    hazard = 1'b1;
    pix("haz_cleared", 160, 0, 0, WHITE);
    hazard = 1'b0;
    check("haz_dist_hold", {21'd0, dist_a}, 32'd1);

    // Distance wrap and pause.
    do_reset();
    speed = 4'd5;
    frames(410);
    check("dist_wrap", {21'd0, dist_a}, 32'd2);
    pause = 1'b1;
    frames(3);
    check("dist_pause", {21'd0, dist_a}, 32'd2);
    pause = 1'b0;

    // Reset while pixels stream, then recovery latency.
    do_reset();
    speed = 4'd10;
    frames(10);
    check("dist_100", {21'd0, dist_a}, 32'd100);
    DrawX = 10'd155; DrawY = 10'd0; pix_valid_in = 1'b1;
    tick();
    tick();
    check("pre_rst_stream", {7'd0, pvo_a, red_a, green_a, blue_a}, {7'd0, 1'b1, WHITE});
    Reset_n = 1'b0;
    #1;
    check("mid_rst_out",  {7'd0, pvo_a, red_a, green_a, blue_a}, 32'd0);
    check("mid_rst_dist", {21'd0, dist_a}, 32'd0);
    speed = 4'd5; frame_start = 1'b1;
    tick();
    tick();
    check("rst_ignores_frame", {21'd0, dist_a}, 32'd0);
    frame_start = 1'b0; pix_valid_in = 1'b0;
    Reset_n = 1'b1;
    tick();
    check("post_rst_idle", {31'd0, pvo_a}, 32'd0);
    pix_valid_in = 1'b1;
    tick();
    pix_valid_in = 1'b0;
    check("post_rst_lat1", {31'd0, pvo_a}, 32'd0);
    tick();
    check("post_rst_lat2", {7'd0, pvo_a, red_a, green_a, blue_a}, {7'd0, 1'b1, WHITE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
